axi4_lite_master: RTL and testbench

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

---
 rtl/axi4_lite_master.sv | 220 ++++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: runs one single-beat read or write per accepted command, with a
// programmable idle delay in front of every VALID/READY it drives.
module axi4_lite_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DLY_W  = 8
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [2:0]          cmd_prot,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  input  logic [DLY_W-1:0]    dly_aw,
  input  logic [DLY_W-1:0]    dly_w,
  input  logic [DLY_W-1:0]    dly_b,
  input  logic [DLY_W-1:0]    dly_ar,
  input  logic [DLY_W-1:0]    dly_r,
  output logic                rsp_valid,
  output logic [DATA_W+1:0]   rsp_data,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [2:0]          AWPROT,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [2:0]          ARPROT,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY
);

  typedef enum logic [2:0] {StIdle, StWr, StWb, StRa, StRd, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2:0]            prot_q, prot_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic [DLY_W-1:0]      dly_b_q, dly_b_d, dly_r_q, dly_r_d;
  // cnt_a: AW or AR delay; cnt_w: W delay; cnt_s: B or R delay.
  logic [DLY_W-1:0]      cnt_a_q, cnt_a_d, cnt_w_q, cnt_w_d, cnt_s_q, cnt_s_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic [DATA_W+1:0]     rsp_data_q, rsp_data_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    prot_d     = prot_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    dly_b_d    = dly_b_q;
    dly_r_d    = dly_r_q;
    cnt_a_d    = cnt_a_q;
    cnt_w_d    = cnt_w_q;
    cnt_s_d    = cnt_s_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          prot_d    = cmd_prot;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          dly_b_d   = dly_b;
          dly_r_d   = dly_r;
          cnt_a_d   = cmd_write ? dly_aw : dly_ar;
          cnt_w_d   = dly_w;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? StWr : StRa;
        end
      end
      StWr: begin
        if (awvalid_q) begin
          if (AWREADY) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
          end
        end else if (!aw_done_q) begin
          if (cnt_a_q == '0) awvalid_d = 1'b1;
          else               cnt_a_d   = cnt_a_q - 1'b1;
        end
        if (wvalid_q) begin
          if (WREADY) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end
        end else if (!w_done_q) begin
          if (cnt_w_q == '0) wvalid_d = 1'b1;
          else               cnt_w_d  = cnt_w_q - 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          cnt_s_d = dly_b_q;
          state_d = StWb;
        end
      end
      StWb: begin
        if (bready_q) begin
          if (BVALID) begin
            bready_d   = 1'b0;
            rsp_data_d = {{DATA_W{1'b0}}, BRESP};
            state_d    = StDone;
          end
        end else if (cnt_s_q == '0) begin
          bready_d = 1'b1;
        end else begin
          cnt_s_d = cnt_s_q - 1'b1;
        end
      end
      StRa: begin
        if (arvalid_q) begin
          if (ARREADY) begin
            arvalid_d = 1'b0;
            cnt_s_d   = dly_r_q;
            state_d   = StRd;
          end
        end else if (cnt_a_q == '0) begin
          arvalid_d = 1'b1;
        end else begin
          cnt_a_d = cnt_a_q - 1'b1;
        end
      end
      StRd: begin
        if (rready_q) begin
          if (RVALID) begin
            rready_d   = 1'b0;
            rsp_data_d = {RDATA, RRESP};
            state_d    = StDone;
          end
        end else if (cnt_s_q == '0) begin
          rready_d = 1'b1;
        end else begin
          cnt_s_d = cnt_s_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      prot_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      dly_b_q    <= '0;
      dly_r_q    <= '0;
      cnt_a_q    <= '0;
      cnt_w_q    <= '0;
      cnt_s_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      prot_q     <= prot_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      dly_b_q    <= dly_b_d;
      dly_r_q    <= dly_r_d;
      cnt_a_q    <= cnt_a_d;
      cnt_w_q    <= cnt_w_d;
      cnt_s_q    <= cnt_s_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign rsp_data  = rsp_data_q;
  assign AWADDR    = addr_q;
  assign AWPROT    = prot_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = addr_q;
  assign ARPROT    = prot_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: the slave side is driven by hand and each
// scenario checks cycle-exact channel behaviour against hand-derived values.
module tb_axi4_lite_master;

  logic        ACLK, ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_prot;
  logic [3:0]  cmd_wstrb;
  logic [7:0]  dly_aw, dly_w, dly_b, dly_ar, dly_r;
  logic        rsp_valid;
  logic [33:0] rsp_data;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;

  int n_checks = 0;
  int n_fail   = 0;

  axi4_lite_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .dly_aw(dly_aw), .dly_w(dly_w), .dly_b(dly_b), .dly_ar(dly_ar), .dly_r(dly_r),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [7:0] aw, input logic [7:0] w,
                       input logic [7:0] b, input logic [7:0] ar, input logic [7:0] r);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_prot = 3'd0;
    dly_aw = aw; dly_w = w; dly_b = b; dly_ar = ar; dly_r = r;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  // Bounded wait for rsp_valid; returns cycles waited, -1 on timeout.
  task automatic wait_rsp(output int n);
    int i;
    i = 0;
    n = -1;
    while (i < 50 && n < 0) begin
      step();
      i++;
      if (rsp_valid) n = i;
    end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    step();
    step();
    n_checks += 6;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    if (rsp_data !== 34'h0) begin n_fail++; $display("FAIL rst_rsp_data got %h want 0", rsp_data); end
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b0) begin
      n_fail++; $display("FAIL rst_handshakes got %b want 00000",
                         {AWVALID, WVALID, BREADY, ARVALID, RREADY});
    end
    if ({AWADDR, ARADDR, WDATA} !== 96'h0) begin
      n_fail++; $display("FAIL rst_addr_data got %h/%h/%h want 0", AWADDR, ARADDR, WDATA);
    end
    if ({WSTRB, AWPROT, ARPROT} !== 10'h0) begin
      n_fail++; $display("FAIL rst_strb_prot got %h/%h/%h want 0", WSTRB, AWPROT, ARPROT);
    end
    ARESETn = 1'b1;
    step();
  endtask

  task automatic test_write_basic();
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    issue(1'b1, 32'h08, 32'hF00AF010, 4'hF, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    n_checks++;
    if ({cmd_ready, AWVALID, WVALID} !== 3'b000) begin
      n_fail++; $display("FAIL wr_accept got %b want 000", {cmd_ready, AWVALID, WVALID});
    end
    step();
    n_checks += 2;
    if ({AWVALID, WVALID} !== 2'b01) begin
      n_fail++; $display("FAIL wr_wvalid_first got %b want 01", {AWVALID, WVALID});
    end
    if ({WDATA, WSTRB} !== {32'hF00AF010, 4'hF}) begin
      n_fail++; $display("FAIL wr_wdata got %h/%h want f00af010/f", WDATA, WSTRB);
    end
    step();
    n_checks += 2;
    if ({AWVALID, WVALID} !== 2'b10) begin
      n_fail++; $display("FAIL wr_awvalid_second got %b want 10", {AWVALID, WVALID});
    end
    if (AWADDR !== 32'h08) begin n_fail++; $display("FAIL wr_awaddr got %h want 8", AWADDR); end
    step();
    n_checks++;
    if ({AWVALID, BREADY} !== 2'b00) begin
      n_fail++; $display("FAIL wr_after_aw got %b want 00", {AWVALID, BREADY});
    end
    step();
    n_checks++;
    if ({BREADY, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL wr_bready got %b want 10", {BREADY, rsp_valid});
    end
    step();
    n_checks++;
    if ({rsp_valid, BREADY, rsp_data} !== {2'b10, 34'h0}) begin
      n_fail++; $display("FAIL wr_done got %b/%b/%h want 1/0/0", rsp_valid, BREADY, rsp_data);
    end
    step();
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL wr_back_idle got %b want 01", {rsp_valid, cmd_ready});
    end
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
  endtask

  task automatic test_read_basic();
    ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'h12345678; RRESP = 2'b00;
    issue(1'b0, 32'h00, 32'h0, 4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    step();
    n_checks++;
    if ({ARVALID, ARADDR} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL rd_arvalid got %b/%h want 1/0", ARVALID, ARADDR);
    end
    step();
    n_checks++;
    if ({ARVALID, RREADY} !== 2'b00) begin
      n_fail++; $display("FAIL rd_after_ar got %b want 00", {ARVALID, RREADY});
    end
    step();
    n_checks++;
    if (RREADY !== 1'b1) begin n_fail++; $display("FAIL rd_rready got %b want 1", RREADY); end
    step();
    n_checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, 34'h048D159E0}) begin
      n_fail++; $display("FAIL rd_done got %b/%h want 1/048d159e0", rsp_valid, rsp_data);
    end
    RDATA = 32'hDEADBEEF;
    step(); step(); step();
    n_checks++;
    if ({rsp_valid, rsp_data} !== {1'b0, 34'h048D159E0}) begin
      n_fail++; $display("FAIL rd_hold got %b/%h want 0/048d159e0", rsp_valid, rsp_data);
    end
    ARREADY = 1'b0; RVALID = 1'b0;
  endtask

  task automatic test_aw_stall();
    int n;
    int bad;
    AWREADY = 1'b0; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b01;
    issue(1'b1, 32'h44, 32'h5555AAAA, 4'h3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    step();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (AWVALID !== 1'b1 || AWADDR !== 32'h44 || rsp_valid !== 1'b0) bad++;
      if (i < 5) step();
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL stall_stable got %0d bad cycles want 0", bad); end
    AWREADY = 1'b1;
    step();
    n_checks++;
    if (AWVALID !== 1'b0) begin n_fail++; $display("FAIL stall_drop got %b want 0", AWVALID); end
    wait_rsp(n);
    n_checks += 2;
    if (n !== 2) begin n_fail++; $display("FAIL stall_latency got %0d want 2", n); end
    if (rsp_data !== 34'h1) begin n_fail++; $display("FAIL stall_bresp got %h want 1", rsp_data); end
    step();
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
  endtask

  task automatic test_error_resp();
    int n;
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b10;
    issue(1'b1, 32'h0C, 32'h1, 4'h1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    wait_rsp(n);
    n_checks += 2;
    if (n !== 4) begin n_fail++; $display("FAIL slverr_latency got %0d want 4", n); end
    if (rsp_data !== 34'h2) begin n_fail++; $display("FAIL slverr_data got %h want 2", rsp_data); end
    step();
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
    ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'h0; RRESP = 2'b11;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    wait_rsp(n);
    n_checks += 2;
    if (n !== 4) begin n_fail++; $display("FAIL decerr_latency got %0d want 4", n); end
    if (rsp_data !== 34'h3) begin n_fail++; $display("FAIL decerr_data got %h want 3", rsp_data); end
    step();
    ARREADY = 1'b0; RVALID = 1'b0;
  endtask

  task automatic test_reset_in_wb();
    int seen;
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0;
    issue(1'b1, 32'h20, 32'h77, 4'hF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    step(); step(); step();
    n_checks++;
    if (BREADY !== 1'b1) begin n_fail++; $display("FAIL wbrst_bready_pre got %b want 1", BREADY); end
    ARESETn = 1'b0;
    step();
    n_checks += 2;
    if ({BREADY, cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL wbrst_state got %b want 01", {BREADY, cmd_ready});
    end
    if (rsp_data !== 34'h0) begin n_fail++; $display("FAIL wbrst_data got %h want 0", rsp_data); end
    ARESETn = 1'b1;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid !== 1'b0 || BREADY !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL wbrst_no_rsp got %0d cycles want 0", seen); end
    BVALID = 1'b0;
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic rdy_after, acc_after;
    logic [33:0] exp_rd;
    exp_rd = {32'hCAFEBABE, 2'b00};
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'hCAFEBABE; RRESP = 2'b00;
    d1 = -1; d2 = -1; rdy_after = 1'bx; acc_after = 1'bx;
    cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h9; cmd_wstrb = 4'hF; cmd_prot = 3'd0;
    dly_aw = 8'd0; dly_w = 8'd0; dly_b = 8'd0; dly_ar = 8'd0; dly_r = 8'd0;
    cmd_valid = 1'b1;
    step();
    cmd_write = 1'b0; cmd_addr = 32'h34;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (rsp_valid) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (d1 >= 0 && k == d1 + 1) rdy_after = cmd_ready;
      if (d1 >= 0 && k == d1 + 2) begin
        acc_after = cmd_ready;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    n_checks += 6;
    if (d1 !== 4) begin n_fail++; $display("FAIL b2b_first got %0d want 4", d1); end
    if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got %b want 1", rdy_after); end
    if (acc_after !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got %b want 0", acc_after); end
    if (d2 !== 10) begin n_fail++; $display("FAIL b2b_second got %0d want 10", d2); end
    if (d2 - d1 < 3) begin n_fail++; $display("FAIL b2b_gap got %0d want >=3", d2 - d1); end
    if (rsp_data !== exp_rd) begin
      n_fail++; $display("FAIL b2b_data got %h want %h", rsp_data, exp_rd);
    end
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
  endtask

  initial begin
    ARESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_prot = '0;
    cmd_wdata = '0; cmd_wstrb = '0;
    dly_aw = '0; dly_w = '0; dly_b = '0; dly_ar = '0; dly_r = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = '0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_aw_stall();
    test_error_resp();
    test_reset_in_wb();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
